// File: rtl/map_blitter.sv
// -----------------------------------------------------------------------------
// map_blitter
//
// Copies one MAP_W x MAP_H tile image, chosen from NUM_MAPS images stored back
// to back in an external ROM, into VGA memory at screen origin (X_OFF, Y_OFF).
// The ROM read latency (MEM_LAT) is hidden by a coordinate pipeline of the same
// depth. Each colour word therefore reaches the VGA port in the same cycle as
// its own x/y coordinates.
//
// Handshake with the control FSM:
//   enable high in IDLE starts a draw.
//   draw_done is raised once every pixel has been written.
//   enable low at any point returns the block to IDLE. An aborted draw never
//   raises draw_done.
//
// Ports
//   clock      in   system clock
//   reset      in   synchronous, active-high reset
//   enable     in   level request: high = draw, low = abort / acknowledge done
//   map_sel    in   image index, sampled only on the IDLE->DRAW step
//   mem_addr   out  ROM read address (registered)
//   mem_q      in   ROM word for the address issued MEM_LAT edges earlier
//   x_pos      out  VGA x coordinate (registered)
//   y_pos      out  VGA y coordinate (registered)
//   colour     out  VGA colour, aligned with x_pos / y_pos
//   VGA_write  out  VGA write enable
//   busy       out  high while drawing or flushing the pipeline
//   draw_done  out  high once the image is complete, until enable drops
//
// ROM timing: a word whose address appears on mem_addr in cycle c is captured
// by the output register on the edge MEM_LAT cycles later.
// -----------------------------------------------------------------------------
module map_blitter #(
  parameter int MAP_W    = 256,
  parameter int MAP_H    = 176,
  parameter int X_OFF    = 0,
  parameter int Y_OFF    = 64,
  parameter int NUM_MAPS = 4,
  parameter int COLOUR_W = 3,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 18,
  localparam int SEL_W   = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [SEL_W-1:0]    map_sel,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [COLOUR_W-1:0] mem_q,
  output logic [8:0]          x_pos,
  output logic [7:0]          y_pos,
  output logic [COLOUR_W-1:0] colour,
  output logic                VGA_write,
  output logic                busy,
  output logic                draw_done
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             IMG_SIZE   = MAP_W * MAP_H;
  localparam logic [8:0]     COL_LAST   = 9'(MAP_W - 1);
  localparam logic [7:0]     ROW_LAST   = 8'(MAP_H - 1);
  localparam logic [8:0]     X_BASE     = 9'(X_OFF);
  localparam logic [7:0]     Y_BASE     = 8'(Y_OFF);
  localparam logic [1:0]     FLUSH_LAST = 2'(MEM_LAT - 1);
  localparam logic [SEL_W:0] SEL_LIMIT  = (SEL_W + 1)'(NUM_MAPS);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (MAP_W < 1 || MAP_W > 320) begin : g_bad_map_w
    $error("map_blitter: MAP_W must be in 1..320");
  end
  if (MAP_H < 1 || MAP_H > 240) begin : g_bad_map_h
    $error("map_blitter: MAP_H must be in 1..240");
  end
  if (X_OFF < 0 || X_OFF + MAP_W - 1 > 319) begin : g_bad_x_span
    $error("map_blitter: image exceeds screen width");
  end
  if (Y_OFF < 0 || Y_OFF + MAP_H - 1 > 239) begin : g_bad_y_span
    $error("map_blitter: image exceeds screen height");
  end
  if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_lat
    $error("map_blitter: MEM_LAT must be in 1..3");
  end
  if (NUM_MAPS < 1 || (NUM_MAPS & (NUM_MAPS - 1)) != 0) begin : g_bad_maps
    $error("map_blitter: NUM_MAPS must be a power of two");
  end
  if (longint'(NUM_MAPS) * longint'(IMG_SIZE) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("map_blitter: ADDR_W too narrow for the ROM contents");
  end

  // Start address of image `sel`. The multiplier is a constant, so this
  // reduces to shifts and adds. The result is used only once, at draw start.
  function automatic logic [ADDR_W-1:0] map_base(input logic [SEL_W-1:0] sel);
    logic [ADDR_W-1:0] sel_wide;
    sel_wide = ADDR_W'(sel);
    return sel_wide * ADDR_W'(IMG_SIZE);
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [1:0]                  state_r;
  logic [1:0]                  state_nx_s;
  logic [8:0]                  col_r;
  logic [8:0]                  col_nx_s;
  logic [7:0]                  row_r;
  logic [7:0]                  row_nx_s;
  logic [1:0]                  flush_cnt_r;
  logic [1:0]                  flush_cnt_nx_s;
  logic [ADDR_W-1:0]           addr_nx_s;
  logic [SEL_W-1:0]            sel_clamped_s;
  logic                        last_pix_s;
  logic                        flush_last_s;
  logic                        clear_s;
  logic                        push_valid_s;
  logic [8:0]                  push_x_s;
  logic [7:0]                  push_y_s;

  // Coordinate pipeline. Index 0 holds the pixel whose address is currently
  // on mem_addr. Index MEM_LAT-1 is the pixel whose word is on mem_q.
  logic [MEM_LAT-1:0]          pipe_valid_r;
  logic [MEM_LAT-1:0][8:0]     pipe_x_r;
  logic [MEM_LAT-1:0][7:0]     pipe_y_r;

  // The col/row counters track the pixel currently presented on mem_addr.
  assign last_pix_s   = (col_r == COL_LAST) && (row_r == ROW_LAST);
  assign flush_last_s = (flush_cnt_r == FLUSH_LAST);

  // Any step into IDLE (abort, acknowledge, or idling) wipes the pipeline
  // and the VGA-side outputs on that same edge.
  assign clear_s      = (state_nx_s == S_IDLE);
  assign push_valid_s = (state_nx_s == S_DRAW);
  assign push_x_s     = X_BASE + col_nx_s;
  assign push_y_s     = Y_BASE + row_nx_s;

  // Fold out-of-range image indices onto image 0.
  always_comb begin
    sel_clamped_s = map_sel;
    if ({1'b0, map_sel} >= SEL_LIMIT) begin
      sel_clamped_s = '0;
    end else begin
      sel_clamped_s = map_sel;
    end
  end

  // Next state, next pixel counters, next ROM address and flush counter.
  always_comb begin
    state_nx_s     = S_IDLE;
    col_nx_s       = 9'd0;
    row_nx_s       = 8'd0;
    flush_cnt_nx_s = 2'd0;
    addr_nx_s      = '0;
    case (state_r)
      S_IDLE: begin
        if (enable) begin
          // Pixel 0 is issued on the same edge that enters DRAW. The image
          // base is folded into the running address here and never needed
          // again, so a change on map_sel mid-draw has nothing to act on.
          state_nx_s = S_DRAW;
          addr_nx_s  = map_base(sel_clamped_s);
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_DRAW: begin
        if (!enable) begin
          state_nx_s = S_IDLE;
        end else if (last_pix_s) begin
          state_nx_s = S_FLUSH;
        end else begin
          state_nx_s = S_DRAW;
          // Images are stored row-major, so the address simply increments,
          // including across a row wrap.
          addr_nx_s  = mem_addr + ADDR_W'(1'b1);
          if (col_r == COL_LAST) begin
            col_nx_s = 9'd0;
            row_nx_s = row_r + 8'd1;
          end else begin
            col_nx_s = col_r + 9'd1;
            row_nx_s = row_r;
          end
        end
      end
      S_FLUSH: begin
        if (!enable) begin
          state_nx_s = S_IDLE;
        end else if (flush_last_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s     = S_FLUSH;
          flush_cnt_nx_s = flush_cnt_r + 2'd1;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State, pixel counters and ROM address register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      col_r       <= 9'd0;
      row_r       <= 8'd0;
      flush_cnt_r <= 2'd0;
      mem_addr    <= '0;
    end else begin
      state_r     <= state_nx_s;
      col_r       <= col_nx_s;
      row_r       <= row_nx_s;
      flush_cnt_r <= flush_cnt_nx_s;
      mem_addr    <= addr_nx_s;
    end
  end

  if (MEM_LAT == 1) begin : g_pipe_one
    // Single-stage coordinate pipeline.
    always_ff @(posedge clock) begin
      if (reset) begin
        pipe_valid_r <= '0;
        pipe_x_r     <= '0;
        pipe_y_r     <= '0;
      end else if (clear_s) begin
        pipe_valid_r <= '0;
        pipe_x_r     <= '0;
        pipe_y_r     <= '0;
      end else begin
        pipe_valid_r <= push_valid_s;
        pipe_x_r     <= push_x_s;
        pipe_y_r     <= push_y_s;
      end
    end
  end else begin : g_pipe_multi
    // Multi-stage coordinate pipeline. Entries shift toward the higher index.
    always_ff @(posedge clock) begin
      if (reset) begin
        pipe_valid_r <= '0;
        pipe_x_r     <= '0;
        pipe_y_r     <= '0;
      end else if (clear_s) begin
        pipe_valid_r <= '0;
        pipe_x_r     <= '0;
        pipe_y_r     <= '0;
      end else begin
        pipe_valid_r <= {pipe_valid_r[MEM_LAT-2:0], push_valid_s};
        pipe_x_r     <= {pipe_x_r[MEM_LAT-2:0], push_x_s};
        pipe_y_r     <= {pipe_y_r[MEM_LAT-2:0], push_y_s};
      end
    end
  end

  // VGA-side output register. The colour word and its coordinates are
  // captured together. They hold while no write is pending, so colour is
  // never X after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      VGA_write <= 1'b0;
      x_pos     <= 9'd0;
      y_pos     <= 8'd0;
      colour    <= '0;
      busy      <= 1'b0;
      draw_done <= 1'b0;
    end else if (clear_s) begin
      VGA_write <= 1'b0;
      x_pos     <= 9'd0;
      y_pos     <= 8'd0;
      colour    <= '0;
      busy      <= 1'b0;
      draw_done <= 1'b0;
    end else begin
      VGA_write <= pipe_valid_r[MEM_LAT-1];
      busy      <= (state_nx_s == S_DRAW) || (state_nx_s == S_FLUSH);
      draw_done <= (state_nx_s == S_DONE);
      if (pipe_valid_r[MEM_LAT-1]) begin
        x_pos  <= pipe_x_r[MEM_LAT-1];
        y_pos  <= pipe_y_r[MEM_LAT-1];
        colour <= mem_q;
      end else begin
        x_pos  <= x_pos;
        y_pos  <= y_pos;
        colour <= colour;
      end
    end
  end

endmodule
